// File: rtl/datapath_unit.sv
// Execution datapath: 16-entry register file, 8-function ALU, synchronous-read
// data RAM and the register-file write-back mux.
module datapath_unit #(
    parameter int DATA_W     = 16,
    parameter int RF_DEPTH   = 16,
    parameter int DMEM_DEPTH = 256,
    parameter int RF_AW      = $clog2(RF_DEPTH),
    parameter int DM_AW      = $clog2(DMEM_DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DM_AW-1:0]  D_Addr,
    input  logic              D_Wr,
    input  logic              RF_s,
    input  logic [RF_AW-1:0]  RF_W_Addr,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_Ra_Addr,
    input  logic [RF_AW-1:0]  RF_Rb_Addr,
    input  logic [2:0]        ALU_s0,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [DATA_W-1:0] ALU_Out,
    output logic              ALU_Zero,
    output logic [DATA_W-1:0] R_Data,
    output logic [DATA_W-1:0] W_Data
);

    logic [DATA_W-1:0] rf_q [RF_DEPTH];
    logic [DATA_W-1:0] rf_d [RF_DEPTH];
    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out, w_data;

    // Register file reads are combinational with no write bypass.
    assign alu_a = rf_q[RF_Ra_Addr];
    assign alu_b = rf_q[RF_Rb_Addr];

    always_comb begin
        alu_out = alu_a;
        case (ALU_s0)
            3'b000:  alu_out = alu_a;
            3'b001:  alu_out = alu_a + alu_b;
            3'b010:  alu_out = alu_a - alu_b;
            3'b011:  alu_out = alu_a & alu_b;
            3'b100:  alu_out = alu_a | alu_b;
            3'b101:  alu_out = alu_a ^ alu_b;
            3'b110:  alu_out = ~alu_a;
            3'b111:  alu_out = alu_a + DATA_W'(1);
            default: alu_out = alu_a;
        endcase
    end

    assign w_data = RF_s ? r_data_q : alu_out;

    always_comb begin
        rf_d = rf_q;
        if (RF_W_en)
            rf_d[RF_W_Addr] = w_data;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            rf_q <= '{default: '0};
        else
            rf_q <= rf_d;
    end

    // Read samples the pre-write contents, giving old-data read-during-write.
    assign r_data_d = dmem_q[D_Addr];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_data_q <= '0;
        else
            r_data_q <= r_data_d;
    end

    // RAM array is never cleared; writes are merely blocked during reset.
    always_ff @(posedge Clk) begin
        if (!Reset && D_Wr)
            dmem_q[D_Addr] <= alu_a;
    end

    assign ALU_A    = alu_a;
    assign ALU_B    = alu_b;
    assign ALU_Out  = alu_out;
    assign ALU_Zero = (alu_out == '0);
    assign R_Data   = r_data_q;
    assign W_Data   = w_data;

endmodule

// File: tb/tb_datapath_unit.sv
// Scoreboard bench for datapath_unit: expected values are queued when stimulus
// is driven and popped when the corresponding output is observable.
module tb_datapath_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  D_Addr = '0;
    logic        D_Wr = 1'b0;
    logic        RF_s = 1'b0;
    logic [3:0]  RF_W_Addr = '0;
    logic        RF_W_en = 1'b0;
    logic [3:0]  RF_Ra_Addr = '0;
    logic [3:0]  RF_Rb_Addr = '0;
    logic [2:0]  ALU_s0 = '0;
    logic [15:0] ALU_A, ALU_B, ALU_Out, R_Data, W_Data;
    logic        ALU_Zero;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] e;

    datapath_unit dut (
        .Clk(Clk), .Reset(Reset), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
        .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr),
        .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_Out(ALU_Out), .ALU_Zero(ALU_Zero), .R_Data(R_Data), .W_Data(W_Data)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Constants are built from the reset-zero state: clear, then double/increment.
    task automatic build(input logic [3:0] r, input logic [15:0] v);
        RF_Ra_Addr = r; RF_Rb_Addr = r; RF_W_Addr = r; RF_W_en = 1'b1;
        RF_s = 1'b0; D_Wr = 1'b0; ALU_s0 = 3'b101;
        tick();
        for (int i = 15; i >= 0; i--) begin
            ALU_s0 = 3'b001;
            tick();
            if (v[i]) begin
                ALU_s0 = 3'b111;
                tick();
            end
        end
        RF_W_en = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        Reset = 1'b1;
        ALU_s0 = 3'b000;
        #1;
        checks++; if (ALU_A !== 16'h0) begin errors++; $display("FAIL reset_alu_a got=%h exp=0000", ALU_A); end
        checks++; if (ALU_B !== 16'h0) begin errors++; $display("FAIL reset_alu_b got=%h exp=0000", ALU_B); end
        checks++; if (R_Data !== 16'h0) begin errors++; $display("FAIL reset_r_data got=%h exp=0000", R_Data); end
        checks++; if (ALU_Out !== 16'h0 || ALU_Zero !== 1'b1) begin
            errors++; $display("FAIL reset_alu_out got=%h/%b exp=0000/1", ALU_Out, ALU_Zero); end
        RF_s = 1'b1; #1;
        checks++; if (W_Data !== 16'h0) begin errors++; $display("FAIL reset_w_data_ram got=%h exp=0000", W_Data); end
        RF_s = 1'b0;
        #13;
        Reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            RF_Ra_Addr = 4'(i); RF_Rb_Addr = 4'(15 - i);
            exp_q.push_back(16'h0);
            #1;
            e = exp_q.pop_front();
            checks++; if (ALU_A !== e || ALU_B !== e) begin
                errors++; $display("FAIL reset_rf%0d got=%h/%h exp=%h", i, ALU_A, ALU_B, e); end
        end
    endtask

    task automatic test_add();
        build(4'd10, 16'h0005);
        build(4'd11, 16'h0007);
        RF_Ra_Addr = 4'd10; RF_Rb_Addr = 4'd11; ALU_s0 = 3'b001;
        RF_W_Addr = 4'd12; RF_W_en = 1'b1; RF_s = 1'b0;
        exp_q.push_back(16'h000C);
        #1;
        e = exp_q.pop_front();
        checks++; if (ALU_Out !== e || W_Data !== e) begin
            errors++; $display("FAIL add_out got=%h/%h exp=%h", ALU_Out, W_Data, e); end
        exp_q.push_back(16'h000C);
        tick();
        RF_W_en = 1'b0; RF_Ra_Addr = 4'd12;
        #1;
        e = exp_q.pop_front();
        checks++; if (ALU_A !== e) begin errors++; $display("FAIL add_wb got=%h exp=%h", ALU_A, e); end
    endtask

    task automatic test_alu();
        logic [15:0] tbl [8];
        tbl = '{16'h0003, 16'h0008, 16'hFFFE, 16'h0001, 16'h0007, 16'h0006, 16'hFFFC, 16'h0004};
        build(4'd1, 16'h0003);
        build(4'd2, 16'h0005);
        RF_Ra_Addr = 4'd1; RF_Rb_Addr = 4'd2; RF_s = 1'b0;
        for (int op = 0; op < 8; op++) begin
            ALU_s0 = 3'(op);
            exp_q.push_back(tbl[op]);
            #1;
            e = exp_q.pop_front();
            checks++; if (ALU_Out !== e || ALU_Zero !== 1'b0) begin
                errors++; $display("FAIL alu_op%0d got=%h/%b exp=%h/0", op, ALU_Out, ALU_Zero, e); end
        end
        RF_Rb_Addr = 4'd1; ALU_s0 = 3'b010; #1;
        checks++; if (ALU_Out !== 16'h0 || ALU_Zero !== 1'b1) begin
            errors++; $display("FAIL sub_zero got=%h/%b exp=0000/1", ALU_Out, ALU_Zero); end
        build(4'd4, 16'hFFFF);
        RF_Ra_Addr = 4'd4; ALU_s0 = 3'b111; #1;
        checks++; if (ALU_Out !== 16'h0 || ALU_Zero !== 1'b1) begin
            errors++; $display("FAIL inc_wrap got=%h/%b exp=0000/1", ALU_Out, ALU_Zero); end
        RF_Rb_Addr = 4'd2; ALU_s0 = 3'b001; #1;
        checks++; if (ALU_Out !== 16'h0004) begin errors++; $display("FAIL add_wrap got=%h exp=0004", ALU_Out); end
    endtask

    task automatic test_store_load();
        // Store R12 while simultaneously writing R13 = R12 + 1.
        RF_Ra_Addr = 4'd12; D_Addr = 8'hBC; D_Wr = 1'b1;
        ALU_s0 = 3'b111; RF_W_Addr = 4'd13; RF_W_en = 1'b1; RF_s = 1'b0;
        tick();
        D_Wr = 1'b0; RF_W_en = 1'b0; RF_s = 1'b1;
        exp_q.push_back(16'h000C);
        tick();
        e = exp_q.pop_front();
        checks++; if (R_Data !== e || W_Data !== e) begin
            errors++; $display("FAIL load_rdata got=%h/%h exp=%h", R_Data, W_Data, e); end
        RF_W_en = 1'b1; RF_W_Addr = 4'd3;
        tick();
        RF_W_en = 1'b0; RF_s = 1'b0; RF_Ra_Addr = 4'd3;
        #1;
        checks++; if (ALU_A !== 16'h000C) begin errors++; $display("FAIL load_r3 got=%h exp=000c", ALU_A); end
        RF_Ra_Addr = 4'd13; #1;
        checks++; if (ALU_A !== 16'h000D) begin errors++; $display("FAIL dual_wr_r13 got=%h exp=000d", ALU_A); end
    endtask

    task automatic test_rdw();
        build(4'd6, 16'h1111);
        build(4'd7, 16'h2222);
        RF_Ra_Addr = 4'd6; D_Addr = 8'h10; D_Wr = 1'b1;
        tick();
        RF_Ra_Addr = 4'd7;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        tick();
        D_Wr = 1'b0;
        e = exp_q.pop_front();
        checks++; if (R_Data !== e) begin errors++; $display("FAIL rdw_old got=%h exp=%h", R_Data, e); end
        tick();
        e = exp_q.pop_front();
        checks++; if (R_Data !== e) begin errors++; $display("FAIL rdw_new got=%h exp=%h", R_Data, e); end
    endtask

    task automatic test_rf_bypass();
        build(4'd5, 16'h0001);
        build(4'd8, 16'hABCC);
        RF_Ra_Addr = 4'd5; RF_Rb_Addr = 4'd8; ALU_s0 = 3'b001;
        RF_W_Addr = 4'd5; RF_W_en = 1'b1; RF_s = 1'b0;
        #1;
        checks++; if (ALU_A !== 16'h0001 || ALU_Out !== 16'hABCD) begin
            errors++; $display("FAIL rf_old got=%h/%h exp=0001/abcd", ALU_A, ALU_Out); end
        tick();
        RF_W_en = 1'b0;
        #1;
        checks++; if (ALU_A !== 16'hABCD) begin errors++; $display("FAIL rf_new got=%h exp=abcd", ALU_A); end
    endtask

    task automatic test_reset_mid_load();
        RF_Ra_Addr = 4'd8; D_Addr = 8'h20; D_Wr = 1'b1; RF_s = 1'b0;
        tick();
        D_Wr = 1'b0; RF_s = 1'b1; RF_W_en = 1'b0;
        exp_q.push_back(16'hABCC);
        tick();
        e = exp_q.pop_front();
        checks++; if (R_Data !== e) begin errors++; $display("FAIL mid_load_c1 got=%h exp=%h", R_Data, e); end
        // Reset lands between the load cycles while writes are being requested.
        RF_W_en = 1'b1; RF_W_Addr = 4'd9; D_Wr = 1'b1; Reset = 1'b1;
        #1;
        checks++; if (R_Data !== 16'h0 || W_Data !== 16'h0) begin
            errors++; $display("FAIL mid_load_rst got=%h/%h exp=0000/0000", R_Data, W_Data); end
        tick();
        Reset = 1'b0; RF_W_en = 1'b0; D_Wr = 1'b0; RF_s = 1'b0; RF_Ra_Addr = 4'd9;
        #1;
        checks++; if (ALU_A !== 16'h0) begin errors++; $display("FAIL mid_load_r9 got=%h exp=0000", ALU_A); end
        RF_Ra_Addr = 4'd8; #1;
        checks++; if (ALU_A !== 16'h0) begin errors++; $display("FAIL mid_load_r8 got=%h exp=0000", ALU_A); end
        RF_s = 1'b1;
        exp_q.push_back(16'hABCC);
        tick();
        e = exp_q.pop_front();
        checks++; if (R_Data !== e || W_Data !== e) begin
            errors++; $display("FAIL ram_kept got=%h/%h exp=%h", R_Data, W_Data, e); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_store_load();
        test_rdw();
        test_rf_bypass();
        test_reset_mid_load();
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
